// File: rtl/piccolo_uart_rx_pkg.sv
// Shared definitions for the Piccolo UART: receiver state encoding and the
// bit-period arithmetic that the transmitter will reuse.
package piccolo_uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int uart_div(input int clock_freq, input int baudrate);
    return (clock_freq + baudrate / 2) / baudrate;
  endfunction

  function automatic int uart_half(input int clock_freq, input int baudrate);
    return uart_div(clock_freq, baudrate) / 2;
  endfunction

endpackage

// File: rtl/piccolo_uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: circular buffer with wrap-bit pointers,
// head byte exposed with valid/ready, dropped pushes reported as overrun.
module piccolo_uart_rx_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       overrun_err
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          overrun_err_q, overrun_err_d;
  logic          empty, full, pop, push_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign pop   = !empty && out_ready;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign push_ok = push && (!full || pop);

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q + PW'(push_ok);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    overrun_err_d = push && full && !pop;
    if (push_ok) mem_d[wr_ptr_q[PW-2:0]] = push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overrun_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overrun_err_q <= overrun_err_d;
      mem_q         <= mem_d;
    end
  end

  assign out_valid   = !empty;
  assign out_data    = mem_q[rd_ptr_q[PW-2:0]];
  assign overrun_err = overrun_err_q;

endmodule

// File: rtl/piccolo_uart_rx.sv
// Host-link UART receiver: synchronises RXD, deserialises 8N1 frames LSB
// first and queues good bytes in a small FIFO toward the command decoder.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line idle, waiting for a falling edge on rxs
//   ST_START | counting to mid start bit to confirm it is still low
//   ST_DATA  | sampling 8 data bits, one every DIV cycles
//   ST_STOP  | waiting to mid stop bit; high pushes, low is a framing error
//   ST_BREAK | after a framing error, waiting for the line to return high
module piccolo_uart_rx
  import piccolo_uart_rx_pkg::*;
#(
  parameter int CLOCK_FREQ      = 50000000,
  parameter int BAUDRATE        = 115200,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_in,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int DIV  = uart_div(CLOCK_FREQ, BAUDRATE);
  localparam int HALF = uart_half(CLOCK_FREQ, BAUDRATE);
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  if (DIV < 4) begin : g_bad_div
    $error("piccolo_uart_rx: CLOCK_FREQ/BAUDRATE gives fewer than 4 clocks per bit");
  end
  if (FIFO_DEPTH_LOG2 < 1 || FIFO_DEPTH_LOG2 > 4) begin : g_bad_depth
    $error("piccolo_uart_rx: FIFO_DEPTH_LOG2 must be 1..4");
  end

  logic      sync1_q, rxs_q, rxs_prev_q;
  logic      rxs, rx_fall;
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          framing_err_q, framing_err_d;
  logic          push;

  // Synchroniser resets to idle-high so a line held low through reset is
  // only seen as a frame start once rxs actually transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rxd_in;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign rxs     = rxs_q;
  assign rx_fall = rxs_prev_q && !rxs;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 1'b1;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    framing_err_d = 1'b0;
    push          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_fall) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving at mid stop bit gives half a bit of slack for the next start.
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          if (rxs) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            framing_err_d = 1'b1;
            state_d       = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      framing_err_q <= framing_err_d;
    end
  end

  assign framing_err = framing_err_q;
  assign busy        = (state_q != ST_IDLE);

  piccolo_uart_rx_fifo #(
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (shift_q),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .overrun_err(overrun_err)
  );

endmodule

// File: tb/tb_piccolo_uart_rx.sv
// Directed plus randomised bench for piccolo_uart_rx against a byte-queue
// model of the receive path (DIV=10, HALF=5).
module tb_piccolo_uart_rx;

  localparam int CF    = 1000000;
  localparam int BR    = 100000;
  localparam int DIV   = (CF + BR / 2) / BR;
  localparam int HALF  = DIV / 2;
  localparam int LAT   = 2 + HALF + 9 * DIV + 1;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd_in = 1'b1;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       framing_err, overrun_err, busy;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, t_start = 0, first_valid_cyc = -1, valid_cycles = 0;
  int fe_cnt = 0, ov_cnt = 0, exp_ov = 0, exp_fe = 0;
  bit valid_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] mq[$];
  logic [7:0] eq[$];

  always #5 clk = ~clk;

  piccolo_uart_rx #(
    .CLOCK_FREQ(CF), .BAUDRATE(BR), .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk(clk), .reset(reset), .rxd_in(rxd_in),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .framing_err(framing_err), .overrun_err(overrun_err), .busy(busy)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      valid_prev = 1'b0;
    end else begin
      if (out_valid && !valid_prev) first_valid_cyc = cyc;
      if (out_valid) valid_cycles++;
      valid_prev = out_valid;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (framing_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
    t_start = cyc;
    rxd_in = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rxd_in = b[i];
      repeat (DIV) tick();
    end
    rxd_in = stop_val;
    repeat (stop_len) tick();
    rxd_in = 1'b1;
  endtask

  // Model: good byte enters the queue unless it is full; ready_now drains at once.
  task automatic model_push(input logic [7:0] b, input bit ready_now);
    if (mq.size() < DEPTH) mq.push_back(b);
    else exp_ov++;
    if (ready_now) eq.push_back(mq.pop_front());
  endtask

  task automatic check_stream(input string tag);
    logic [31:0] obs;
    check({tag, "_count"}, got_q.size(), eq.size());
    for (int i = 0; i < eq.size(); i++) begin
      obs = (i < got_q.size()) ? {24'd0, got_q[i]} : 'x;
      check($sformatf("%s_byte%0d", tag, i), obs, {24'd0, eq[i]});
    end
    got_q.delete();
    eq.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 4 * DEPTH) begin
      tick();
      n++;
    end
    while (mq.size() > 0) eq.push_back(mq.pop_front());
    check({tag, "_drained"}, out_valid, 1'b0);
    check_stream(tag);
  endtask

  initial begin
    int vc0, ov0, fe0, n, nb;
    bit seen_busy;
    logic [7:0] b;

    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_framing", framing_err, 1'b0);
    check("rst_overrun", overrun_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (5) tick();

    // single frame, latency and one-cycle valid
    out_ready = 1'b1;
    vc0 = valid_cycles;
    send_frame(8'hA5, 1'b1, DIV);
    model_push(8'hA5, 1'b1);
    repeat (5) tick();
    check("a5_latency", first_valid_cyc - t_start, LAT);
    check("a5_valid_cycles", valid_cycles - vc0, 1);
    check_stream("a5");

    // 3-cycle glitch
    fe0 = fe_cnt;
    vc0 = valid_cycles;
    rxd_in = 1'b0;
    repeat (3) tick();
    rxd_in = 1'b1;
    seen_busy = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (busy) seen_busy = 1'b1;
    end while ((busy || !seen_busy) && n < 8);
    check("glitch_busy_seen", seen_busy, 1'b1);
    check("glitch_busy_low", busy, 1'b0);
    repeat (20) tick();
    check("glitch_no_valid", valid_cycles - vc0, 0);
    check("glitch_no_ferr", fe_cnt - fe0, 0);

    // framing error then recovery
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 30);
    exp_fe++;
    repeat (10) tick();
    check("ferr_pulses", fe_cnt - fe0, 1);
    send_frame(8'h55, 1'b1, DIV);
    model_push(8'h55, 1'b1);
    repeat (5) tick();
    check_stream("ferr_then_55");

    // overrun with five back-to-back frames
    out_ready = 1'b0;
    ov0 = ov_cnt;
    exp_ov = 0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, DIV);
      model_push(8'(i), 1'b0);
    end
    repeat (5) tick();
    check("ovr_pulses", ov_cnt - ov0, exp_ov);
    check("ovr_head_valid", out_valid, 1'b1);
    check("ovr_head_data", out_data, mq[0]);
    drain("ovr");

    // push of 0x66 while full, with a pop in the same cycle
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1, DIV);
      model_push(8'(i), 1'b0);
    end
    ov0 = ov_cnt;
    fork
      send_frame(8'h66, 1'b1, DIV);
      begin
        repeat (LAT - 1) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    join
    eq.push_back(mq.pop_front());
    model_push(8'h66, 1'b0);
    repeat (5) tick();
    check("simul_no_overrun", ov_cnt - ov0, 0);
    check("simul_head", out_data, mq[0]);
    drain("simul");

    // reset in the middle of data bit 4
    out_ready = 1'b0;
    rxd_in = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 4; i++) begin
      rxd_in = 1'(i[0]);
      repeat (DIV) tick();
    end
    rxd_in = 1'b1;
    repeat (HALF) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mq.delete();
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", out_valid, 1'b0);
    repeat (20) tick();
    out_ready = 1'b1;
    send_frame(8'h81, 1'b1, DIV);
    model_push(8'h81, 1'b1);
    repeat (5) tick();
    check_stream("after_rst_81");

    // random bytes, random gaps, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, DIV);
      model_push(b, 1'b1);
      repeat ($urandom_range(0, 15)) tick();
    end
    repeat (5) tick();
    check_stream("rand_ready");

    // random burst into a stalled consumer
    out_ready = 1'b0;
    ov0 = ov_cnt;
    exp_ov = 0;
    nb = $urandom_range(3, 6);
    for (int i = 0; i < nb; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, DIV);
      model_push(b, 1'b0);
    end
    repeat (5) tick();
    check("rand_burst_ovr", ov_cnt - ov0, exp_ov);
    drain("rand_burst");
    check("total_ferr", fe_cnt, exp_fe);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
